// File: rtl/fetch_stage_pkg.sv
// Shared pipeline types and constants for the fetch stage and IF/DE latch.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    PC4    = 2'd0,
    JR     = 2'd1,
    JUMP   = 2'd2,
    BRANCH = 2'd3
  } pcsel_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
  } ifde_t;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_next_pc_mux.sv
// Combinational next-PC formation: PC+4, jr, jump or branch target.
module next_pc_mux
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  pcsel_t      pcsel,
  input  logic [31:0] jr_addr,
  input  logic [25:0] j_index,
  input  logic [31:0] br_target,
  input  logic [31:0] de_npc,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    case (pcsel)
      PC4:     next_pc = pc_plus4;
      JR:      next_pc = jr_addr;
      // Jump region comes from the instruction in decode, not from the fetch PC.
      JUMP:    next_pc = {de_npc[31:28], j_index, 2'b00};
      BRANCH:  next_pc = br_target;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, RUN/HALT FSM and IF/DE latch.
// Optional fetch_count port and counter enabled by FETCH_COUNT_EN.
module fetch_stage #(
  parameter logic [31:0] PC_INIT   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        pcen,
  input  logic        deen,
  input  logic        deflush,
  input  logic [1:0]  PCSel,
  input  logic [31:0] jr_addr,
  input  logic [25:0] j_index,
  input  logic [31:0] br_target,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] de_instr,
  output logic [31:0] de_npc,
  output logic        de_valid,
  output logic        fetch_halted
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  import fetch_stage_pkg::*;

  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  fetch_state_t state;
  ifde_t        de;

  next_pc_mux u_next_pc_mux (
    .pc        (pc),
    .pcsel     (pcsel_t'(PCSel)),
    .jr_addr   (jr_addr),
    .j_index   (j_index),
    .br_target (br_target),
    .de_npc    (de.npc),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc    <= PC_INIT;
      state <= RUN;
      de    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (pcen && ihit)
            pc <= next_pc;
          if (de.valid && (de.instr == HALT_WORD) && !deflush)
            state <= HALT;
        end
        HALT: begin
          // A flush means the HALT was wrong-path: redirect without waiting on ihit.
          if (deflush) begin
            state <= RUN;
            pc    <= next_pc;
          end
        end
        default: state <= RUN;
      endcase

      if (deflush)
        de <= '{instr: NOP_WORD, npc: '0, valid: 1'b0};
      else if (deen && (state == RUN))
        de <= '{instr: imemload, npc: pc_plus4, valid: 1'b1};
    end
  end

`ifdef FETCH_COUNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      fetch_count <= '0;
    else if (!deflush && deen && (state == RUN))
      fetch_count <= fetch_count + 32'd1;
  end
`endif

  assign imemREN      = (state == RUN);
  assign imemaddr     = pc;
  assign de_instr     = de.instr;
  assign de_npc       = de.npc;
  assign de_valid     = de.valid;
  assign fetch_halted = (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        pcen;
  logic        deen;
  logic        deflush;
  logic [1:0]  PCSel;
  logic [31:0] jr_addr;
  logic [25:0] j_index;
  logic [31:0] br_target;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] de_instr;
  logic [31:0] de_npc;
  logic        de_valid;
  logic        fetch_halted;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  fetch_stage #(
    .PC_INIT   (32'h0000_0000),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .imemload     (imemload),
    .pcen         (pcen),
    .deen         (deen),
    .deflush      (deflush),
    .PCSel        (PCSel),
    .jr_addr      (jr_addr),
    .j_index      (j_index),
    .br_target    (br_target),
    .imemREN      (imemREN),
    .imemaddr     (imemaddr),
    .de_instr     (de_instr),
    .de_npc       (de_npc),
    .de_valid     (de_valid),
    .fetch_halted (fetch_halted)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count  (fetch_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; imemload = 32'h2001_0005; pcen = 1'b0; deen = 1'b0;
    deflush = 1'b0; PCSel = 2'd0; jr_addr = '0; j_index = '0; br_target = '0;
    #2;
    chk("rst_ren",   {31'd0, imemREN},      32'd1);
    chk("rst_addr",  imemaddr,              32'h0);
    chk("rst_valid", {31'd0, de_valid},     32'd0);
    chk("rst_instr", de_instr,              32'h0);
    chk("rst_halt",  {31'd0, fetch_halted}, 32'd0);
`ifdef FETCH_COUNT_EN
    chk("rst_cnt",   fetch_count,           32'd0);
`endif
    tick();
    nRST = 1'b1; ihit = 1'b1; pcen = 1'b1; deen = 1'b1;

    tick();
    chk("run1_addr",  imemaddr, 32'h4);
    chk("run1_instr", de_instr, 32'h2001_0005);
    chk("run1_npc",   de_npc,   32'h4);
    chk("run1_valid", {31'd0, de_valid}, 32'd1);
    tick();
    chk("run2_addr",  imemaddr, 32'h8);
    chk("run2_npc",   de_npc,   32'h8);

    ihit = 1'b0; deen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", imemaddr, 32'h8);
      chk("stall_npc",  de_npc,   32'h8);
    end
    ihit = 1'b1; deen = 1'b1;
    tick();
    chk("resume_addr", imemaddr, 32'hC);
    chk("resume_npc",  de_npc,   32'hC);

    // branch with flush; deen also high so flush must win
    PCSel = 2'd3; br_target = 32'h40; deflush = 1'b1;
    tick();
    chk("br_addr",  imemaddr, 32'h40);
    chk("br_valid", {31'd0, de_valid}, 32'd0);
    chk("br_instr", de_instr, 32'h0);
    chk("br_npc",   de_npc,   32'h0);

    br_target = 32'h1000_0004;
    tick();
    PCSel = 2'd0; deflush = 1'b0;
    tick();
    chk("jprep_npc",  de_npc,   32'h1000_0008);
    chk("jprep_addr", imemaddr, 32'h1000_0008);
    PCSel = 2'd2; j_index = 26'h10; deflush = 1'b1;
    tick();
    chk("jump_addr", imemaddr, 32'h1000_0040);

    PCSel = 2'd0; deflush = 1'b0; deen = 1'b0; pcen = 1'b0;
    tick();
    chk("pcen_hold", imemaddr, 32'h1000_0040);

    PCSel = 2'd3; br_target = 32'hFFFF_FFFC; pcen = 1'b1; deflush = 1'b1;
    tick();
    chk("wrap_pre", imemaddr, 32'hFFFF_FFFC);
    PCSel = 2'd0; deflush = 1'b0; deen = 1'b1;
    tick();
    chk("wrap_addr", imemaddr, 32'h0);
    chk("wrap_npc",  de_npc,   32'h0);

    imemload = 32'hFFFF_FFFF;
    tick();
    chk("halt_latched", de_instr, 32'hFFFF_FFFF);
    chk("halt_notyet",  {31'd0, fetch_halted}, 32'd0);
    imemload = 32'h2001_0005;
    tick();
    chk("halt_flag",  {31'd0, fetch_halted}, 32'd1);
    chk("halt_ren",   {31'd0, imemREN},      32'd0);
    chk("halt_addr",  imemaddr, 32'h8);
    chk("halt_next",  de_instr, 32'h2001_0005);
    tick();
    chk("halt_frozen", imemaddr, 32'h8);
    chk("halt_npc",    de_npc,   32'h8);

    deflush = 1'b1; PCSel = 2'd1; jr_addr = 32'h80; ihit = 1'b0;
    tick();
    chk("unhalt_flag",  {31'd0, fetch_halted}, 32'd0);
    chk("unhalt_ren",   {31'd0, imemREN},      32'd1);
    chk("unhalt_addr",  imemaddr, 32'h80);
    chk("unhalt_valid", {31'd0, de_valid},     32'd0);

    // asynchronous reset mid-stream, away from a clock edge
    deflush = 1'b0; PCSel = 2'd0; ihit = 1'b1;
    tick();
    #2 nRST = 1'b0;
    #1;
    chk("arst_addr",  imemaddr, 32'h0);
    chk("arst_valid", {31'd0, de_valid}, 32'd0);
    tick();
    nRST = 1'b1;

    for (int i = 0; i < 5; i++) tick();
    deflush = 1'b1;
    tick();
    chk("cnt_addr",  imemaddr, 32'h18);
    chk("cnt_valid", {31'd0, de_valid}, 32'd0);
`ifdef FETCH_COUNT_EN
    chk("cnt_value", fetch_count, 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
